// File: rtl/hdmi_init_pkg.sv
// Shared types and constants for the HDMI transmitter init sequencer.
package hdmi_init_pkg;

  typedef enum logic [2:0] {
    POWERUP     = 3'd0,
    FETCH       = 3'd1,
    ISSUE       = 3'd2,
    WAIT_ACCEPT = 3'd3,
    WAIT_IDLE   = 3'd4,
    GAP         = 3'd5,
    DONE        = 3'd6,
    ERROR       = 3'd7
  } state_t;

  // Cycles the writer gets to raise busy after a start before we give up.
  localparam int ACCEPT_LIMIT = 4;

  localparam logic [6:0] DEFAULT_DEV_ADDR = 7'h39;

endpackage

// File: rtl/hdmi_init_rom.sv
// Register/value table for the HDMI transmitter bring-up, registered output (1-cycle latency).
module hdmi_init_rom
  import hdmi_init_pkg::*;
#(
  parameter int NUM_REGS = 16
) (
  input  logic       clk,
  input  logic [7:0] index,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_val
);

  logic [15:0] entry;

  // Entries at or beyond NUM_REGS read as zero so a short table cannot leak later rows.
  always_comb begin
    entry = 16'h0000;
    if (int'(index) < NUM_REGS) begin
      case (index)
        8'd0:    entry = 16'h4110;
        8'd1:    entry = 16'h9803;
        8'd2:    entry = 16'h9ae0;
        8'd3:    entry = 16'h9c30;
        8'd4:    entry = 16'h9d61;
        8'd5:    entry = 16'ha2a4;
        8'd6:    entry = 16'ha3a4;
        8'd7:    entry = 16'he0d0;
        8'd8:    entry = 16'hf900;
        8'd9:    entry = 16'h1500;
        8'd10:   entry = 16'h1630;
        8'd11:   entry = 16'h1702;
        8'd12:   entry = 16'h1846;
        8'd13:   entry = 16'haf06;
        8'd14:   entry = 16'h0100;
        8'd15:   entry = 16'h0218;
        default: entry = 16'h0000;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    {reg_addr, reg_val} <= entry;
  end

endmodule

// File: rtl/hdmi_init_sequencer.sv
// Walks the register table and issues one 3-byte I2C write per entry to the HDMI transmitter.
// Optional HDMI_INIT_HPD_EN adds an hpd input whose synchronised rising edge reruns the table.
module hdmi_init_sequencer
  import hdmi_init_pkg::*;
#(
  parameter int         NUM_REGS       = 16,
  parameter logic [6:0] DEV_ADDR       = DEFAULT_DEV_ADDR,
  parameter int         POWERUP_CYCLES = 200000,
  parameter int         GAP_CYCLES     = 64,
  parameter int         BUSY_TIMEOUT   = 4096
) (
  input  logic       clk,
  input  logic       rst,
  output logic [6:0] i2c_addr,
  output logic [7:0] i2c_data_0,
  output logic [7:0] i2c_data_1,
  output logic       i2c_start,
  input  logic       i2c_busy,
  input  logic       restart,
  output logic       init_done,
  output logic       init_error,
  output logic [7:0] init_index,
`ifdef HDMI_INIT_HPD_EN
  input  logic       hpd,
`endif
  output logic [2:0] dbg_state
);

  localparam logic [7:0]  LAST_INDEX   = 8'(NUM_REGS - 1);
  localparam logic [31:0] POWERUP_LAST = 32'(POWERUP_CYCLES - 1);
  localparam logic [31:0] GAP_LAST     = 32'(GAP_CYCLES - 1);
  localparam logic [31:0] BUSY_LAST    = 32'(BUSY_TIMEOUT - 1);
  localparam logic [31:0] ACCEPT_LAST  = 32'(ACCEPT_LIMIT - 1);

  state_t      state;
  logic [31:0] cnt;
  logic [7:0]  index;
  logic [7:0]  rom_reg;
  logic [7:0]  rom_val;
  logic        rerun;

  assign i2c_addr   = DEV_ADDR;
  assign init_index = index;
  assign dbg_state  = state;

  hdmi_init_rom #(.NUM_REGS(NUM_REGS)) u_rom (
    .clk      (clk),
    .index    (index),
    .reg_addr (rom_reg),
    .reg_val  (rom_val)
  );

`ifdef HDMI_INIT_HPD_EN
  logic hpd_meta;
  logic hpd_sync;
  logic hpd_prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      hpd_meta <= 1'b0;
      hpd_sync <= 1'b0;
      hpd_prev <= 1'b0;
    end else begin
      hpd_meta <= hpd;
      hpd_sync <= hpd_meta;
      hpd_prev <= hpd_sync;
    end
  end

  assign rerun = restart | (hpd_sync & ~hpd_prev);
`else
  assign rerun = restart;
`endif

  // Handshake: i2c_start is a one-cycle pulse raised only while the writer is idle; the
  // writer raises i2c_busy on the edge that samples start and drops it when the transfer
  // ends. i2c_data_0/1 stay frozen from the start pulse until the following gap completes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= POWERUP;
      cnt        <= '0;
      index      <= '0;
      i2c_start  <= 1'b0;
      init_done  <= 1'b0;
      init_error <= 1'b0;
      i2c_data_0 <= 8'h00;
      i2c_data_1 <= 8'h00;
    end else begin
      i2c_start <= 1'b0;
      case (state)
        POWERUP: begin
          if (cnt == POWERUP_LAST) begin
            state <= FETCH;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        // First cycle presents the index to the ROM, second cycle captures its output.
        FETCH: begin
          if (cnt == 32'd1) begin
            i2c_data_0 <= rom_reg;
            i2c_data_1 <= rom_val;
            i2c_start  <= 1'b1;
            state      <= ISSUE;
            cnt        <= '0;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        ISSUE: begin
          state <= WAIT_ACCEPT;
          cnt   <= '0;
        end
        WAIT_ACCEPT: begin
          if (i2c_busy) begin
            // The accepting cycle already counts towards the busy timeout.
            state <= WAIT_IDLE;
            cnt   <= 32'd1;
          end else if (cnt == ACCEPT_LAST) begin
            state      <= ERROR;
            init_error <= 1'b1;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        WAIT_IDLE: begin
          if (!i2c_busy) begin
            state <= GAP;
            cnt   <= '0;
          end else if (cnt == BUSY_LAST) begin
            state      <= ERROR;
            init_error <= 1'b1;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        GAP: begin
          if (cnt == GAP_LAST) begin
            cnt <= '0;
            if (index == LAST_INDEX) begin
              state     <= DONE;
              init_done <= 1'b1;
            end else begin
              index <= index + 8'd1;
              state <= FETCH;
            end
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        DONE, ERROR: begin
          if (rerun) begin
            index      <= '0;
            cnt        <= '0;
            init_done  <= 1'b0;
            init_error <= 1'b0;
            state      <= FETCH;
          end
        end
        default: begin
          state <= POWERUP;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hdmi_init_sequencer.sv
// Directed self-checking bench for hdmi_init_sequencer with a behavioural I2C writer model.
module tb_hdmi_init_sequencer;

  localparam int NUM_REGS     = 3;
  localparam int PU_CYCLES    = 10;
  localparam int GAP_CYC      = 4;
  localparam int BUSY_TO      = 100;

  localparam int WR_NORMAL = 0;
  localparam int WR_SILENT = 1;
  localparam int WR_STUCK  = 2;

  localparam int W_DONE      = 0;
  localparam int W_ERROR     = 1;
  localparam int W_START     = 2;
  localparam int W_IDX1_IDLE = 3;
  localparam int W_IDX2_IDLE = 4;

  localparam logic [2:0] ST_POWERUP   = 3'd0;
  localparam logic [2:0] ST_WAIT_IDLE = 3'd4;
  localparam logic [2:0] ST_ERROR     = 3'd7;

  logic       clk;
  logic       rst;
  logic [6:0] i2c_addr;
  logic [7:0] i2c_data_0;
  logic [7:0] i2c_data_1;
  logic       i2c_start;
  logic       i2c_busy;
  logic       restart;
  logic       init_done;
  logic       init_error;
  logic [7:0] init_index;
  logic [2:0] dbg_state;
`ifdef HDMI_INIT_HPD_EN
  logic       hpd;
`endif

  hdmi_init_sequencer #(
    .NUM_REGS       (NUM_REGS),
    .POWERUP_CYCLES (PU_CYCLES),
    .GAP_CYCLES     (GAP_CYC),
    .BUSY_TIMEOUT   (BUSY_TO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .i2c_addr   (i2c_addr),
    .i2c_data_0 (i2c_data_0),
    .i2c_data_1 (i2c_data_1),
    .i2c_start  (i2c_start),
    .i2c_busy   (i2c_busy),
    .restart    (restart),
    .init_done  (init_done),
    .init_error (init_error),
    .init_index (init_index),
`ifdef HDMI_INIT_HPD_EN
    .hpd        (hpd),
`endif
    .dbg_state  (dbg_state)
  );

  // ---------------- clock / reset ----------------
  int cyc = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard state ----------------
  logic [15:0] exp_q[$];
  logic [15:0] cap_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int n_starts = 0;
  int width_err = 0;
  int busy_err = 0;
  int data_changes = 0;
  int start_rise_cyc = 0;
  int start_mark = 0;
  int wr_mode = WR_NORMAL;
  int busy_len = 50;
  bit prev_start = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Start-pulse monitor: width, overlap with busy, and the cycle the pulse rose.
  initial begin
    forever begin
      @(negedge clk);
      if (i2c_start === 1'b1) begin
        n_starts++;
        if (prev_start) width_err++;
        if (i2c_busy) busy_err++;
        start_rise_cyc = cyc;
      end
      prev_start = (i2c_start === 1'b1);
    end
  end

  // Writer model: raise busy on the edge that samples start, capture the data, watch it stay put.
  initial begin
    logic [15:0] held;
    int n;
    i2c_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (i2c_start === 1'b1 && !rst && wr_mode != WR_SILENT) begin
        @(posedge clk);
        #2;
        if (!rst) begin
          i2c_busy = 1'b1;
          held = {i2c_data_0, i2c_data_1};
          cap_q.push_back(held);
          n = 0;
          while (!rst && (wr_mode == WR_STUCK || n < busy_len)) begin
            @(posedge clk);
            #2;
            n++;
            if (!rst && {i2c_data_0, i2c_data_1} != held) data_changes++;
          end
          i2c_busy = 1'b0;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  function automatic logic cond_met(input int which);
    case (which)
      W_DONE:      return init_done;
      W_ERROR:     return init_error;
      W_START:     return n_starts > start_mark;
      W_IDX1_IDLE: return init_index == 8'd1 && dbg_state == ST_WAIT_IDLE;
      W_IDX2_IDLE: return init_index == 8'd2 && dbg_state == ST_WAIT_IDLE;
      default:     return 1'b0;
    endcase
  endfunction

  task automatic wait_until(input int which, input int limit, input string tag);
    int n = 0;
    while (!cond_met(which) && n < limit) begin
      @(posedge clk);
      #1;
      n++;
    end
    check(tag, 32'(cond_met(which)), 32'd1);
  endtask

  task automatic wait_start(input int limit, input string tag);
    start_mark = n_starts;
    wait_until(W_START, limit, tag);
  endtask

  task automatic pulse_restart(output int edge_cyc);
    restart = 1'b1;
    @(posedge clk);
    #1;
    edge_cyc = cyc;
    restart = 1'b0;
  endtask

  task automatic push_table(input int count);
    logic [15:0] tbl [0:2];
    tbl[0] = 16'h4110;
    tbl[1] = 16'h9803;
    tbl[2] = 16'h9ae0;
    for (int i = 0; i < count; i++) exp_q.push_back(tbl[i]);
  endtask

  task automatic drain_sb(input string tag);
    check({tag, "_count"}, 32'(cap_q.size()), 32'(exp_q.size()));
    while (exp_q.size() > 0 && cap_q.size() > 0)
      check({tag, "_data"}, 32'(cap_q.pop_front()), 32'(exp_q.pop_front()));
    cap_q.delete();
    exp_q.delete();
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int rel_cyc;
    int t_edge;
    int first_s;
    int mark;

    rst = 1'b1;
    restart = 1'b0;
`ifdef HDMI_INIT_HPD_EN
    hpd = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    check("rst_start", 32'(i2c_start), 32'd0);
    check("rst_done", 32'(init_done), 32'd0);
    check("rst_error", 32'(init_error), 32'd0);
    check("rst_index", 32'(init_index), 32'd0);
    check("rst_data0", 32'(i2c_data_0), 32'h00);
    check("rst_data1", 32'(i2c_data_1), 32'h00);
    check("rst_state", 32'(dbg_state), 32'(ST_POWERUP));
    check("dev_addr", 32'(i2c_addr), 32'h39);
    rst = 1'b0;
    rel_cyc = cyc;

    // Full run; a restart mid-sequence must be ignored.
    push_table(3);
    wait_start(100, "first_start_seen");
    check("first_start_latency", 32'(start_rise_cyc + 1 - rel_cyc), 32'd13);
    first_s = start_rise_cyc + 1;
    wait_start(200, "second_start_seen");
    check("start_spacing", 32'(start_rise_cyc + 1 - first_s), 32'd58);
    wait_until(W_IDX1_IDLE, 100, "idx1_wait_idle_seen");
    pulse_restart(t_edge);
    wait_until(W_DONE, 500, "done_seen");
    check("done_latency", 32'(cyc - (start_rise_cyc + 1)), 32'd55);
    check("starts_run1", 32'(n_starts), 32'd3);
    check("done_index", 32'(init_index), 32'd2);
    check("done_no_error", 32'(init_error), 32'd0);
    drain_sb("run1");

    // Restart from DONE.
    push_table(3);
    pulse_restart(t_edge);
    check("restart_clears_done", 32'(init_done), 32'd0);
    wait_start(20, "restart_start_seen");
    check("restart_latency", 32'(start_rise_cyc + 1 - t_edge), 32'd3);
    check("restart_index", 32'(init_index), 32'd0);

    // Reset during WAIT_IDLE of entry 2.
    wait_until(W_IDX2_IDLE, 500, "idx2_wait_idle_seen");
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_start", 32'(i2c_start), 32'd0);
    check("midrst_done", 32'(init_done), 32'd0);
    check("midrst_index", 32'(init_index), 32'd0);
    check("midrst_state", 32'(dbg_state), 32'(ST_POWERUP));
    check("midrst_data0", 32'(i2c_data_0), 32'h00);
    @(posedge clk);
    #1;
    rst = 1'b0;
    rel_cyc = cyc;
    drain_sb("run2");

    // Writer never accepts.
    wr_mode = WR_SILENT;
    wait_start(100, "silent_start_seen");
    check("post_reset_latency", 32'(start_rise_cyc + 1 - rel_cyc), 32'd13);
    wait_until(W_ERROR, 20, "accept_error_seen");
    check("accept_timeout_latency", 32'(cyc - start_rise_cyc), 32'd5);
    check("accept_error_index", 32'(init_index), 32'd0);
    check("accept_error_state", 32'(dbg_state), 32'(ST_ERROR));
    mark = n_starts;
    repeat (20) @(posedge clk);
    #1;
    check("no_start_in_error", 32'(n_starts), 32'(mark));
    check("error_held", 32'(init_error), 32'd1);

    // Writer stuck busy: restart from ERROR, then busy timeout.
    wr_mode = WR_STUCK;
    push_table(1);
    pulse_restart(t_edge);
    check("restart_clears_error", 32'(init_error), 32'd0);
    check("restart_err_index", 32'(init_index), 32'd0);
    wait_start(20, "stuck_start_seen");
    check("restart_err_latency", 32'(start_rise_cyc + 1 - t_edge), 32'd3);
    wait_until(W_ERROR, 200, "busy_error_seen");
    check("busy_timeout_latency", 32'(cyc - (start_rise_cyc + 1)), 32'd100);
    check("busy_error_index", 32'(init_index), 32'd0);
    wr_mode = WR_NORMAL;
    repeat (3) @(posedge clk);
    #1;
    drain_sb("stuck");

    // Recover from ERROR with a healthy writer.
    push_table(3);
    mark = n_starts;
    pulse_restart(t_edge);
    wait_until(W_DONE, 500, "recover_done_seen");
    check("recover_starts", 32'(n_starts - mark), 32'd3);
    drain_sb("recover");

`ifdef HDMI_INIT_HPD_EN
    push_table(3);
    hpd = 1'b1;
    @(posedge clk);
    #1;
    t_edge = cyc;
    wait_start(20, "hpd_start_seen");
    check("hpd_latency", 32'(start_rise_cyc + 1 - t_edge), 32'd5);
    check("hpd_index", 32'(init_index), 32'd0);
    wait_until(W_DONE, 500, "hpd_done_seen");
    drain_sb("hpd");
`endif

    check("start_width", 32'(width_err), 32'd0);
    check("start_while_busy", 32'(busy_err), 32'd0);
    check("data_stable", 32'(data_changes), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
